qspi_wb_arbiter: RTL and testbench
==================================

QSPI_WB_ARBITER -- requirements
Module: qspi_wb_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16'd4096: max cycles a slave strobe may wait for ack before abort.
REQ-002 SHALL have port clk_i  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have, for N in {0,1} (N=0 instruction-fetch master, N=1 data master), ports mN_cyc_i in 1, mN_stb_i in 1, mN_we_i in 1, mN_adr_i in 8, mN_dat_i in 32, mN_sel_i in 4: Wishbone master request.
REQ-005 SHALL have, for N in {0,1}, ports mN_ack_o out 1, mN_err_o out 1, mN_dat_o out 32: Wishbone response to master N.
REQ-006 SHALL have ports s_cyc_o out 1, s_stb_o out 1, s_we_o out 1, s_adr_o out 8, s_dat_o out 32, s_sel_o out 4: request to the SPI controller slave port.
REQ-007 SHALL have ports s_ack_i in 1, s_dat_i in 32: SPI controller response.
REQ-008 SHALL have port grant_o  output  2  one-hot current owner (01=m0, 10=m1, 00=none).

Function
REQ-009 SHALL implement states IDLE, OWN0, OWN1 with registered grant.
REQ-010 IDLE: only m0_cyc_i high -> OWN0; only m1_cyc_i high -> OWN1; both high -> master not granted last (round-robin); neither -> stay IDLE.
REQ-011 Grant latency: request sampled at edge t, owner's signals reach slave port after edge t, i.e. one cycle.
REQ-012 OWNn held while mN_cyc_i high (locks CCR/ADR/DR sequence of one flash operation); mN_cyc_i low at an edge -> IDLE.
REQ-013 SHALL spend minimum one cycle in IDLE between owners; no direct OWN0<->OWN1 transition.
REQ-014 In OWNn, s_cyc_o/s_we_o/s_adr_o/s_sel_o/s_dat_o SHALL combinationally equal master N inputs; s_stb_o = mN_stb_i AND NOT abort.
REQ-015 In IDLE, all s_* outputs SHALL be 0.
REQ-016 mN_ack_o = s_ack_i AND owner==N; mN_dat_o = s_dat_i when owner==N, else 32'h0; non-owner ack/err always 0.
REQ-017 last-grant register SHALL update on every IDLE->OWNn transition to N.
REQ-018 Timeout counter (16 bit) SHALL increment each cycle s_stb_o=1 and s_ack_i=0; clears on s_ack_i=1, s_stb_o=0, or leaving OWNn.
REQ-019 When counter == TIMEOUT-1 with no ack, next cycle abort=1: mN_err_o=1 for exactly one cycle, s_stb_o forced 0 that cycle, counter clears; ownership retained.
REQ-020 s_ack_i and abort in same cycle: ack wins, err not asserted.
REQ-021 mN_cyc_i drop in same cycle as s_ack_i: ack still routed to N that cycle, release at next edge.
REQ-022 s_ack_i while IDLE SHALL be ignored (no master ack).
REQ-023 grant_o SHALL reflect registered state (OWN0=01, OWN1=10, IDLE=00).

Reset
REQ-024 rst_ni low SHALL immediately force state IDLE, last-grant=m1 (so m0 wins first tie), counter 0, abort 0, grant_o=00, all s_* and mN_* outputs 0.
REQ-025 Reset mid-transfer SHALL drop s_cyc_o/s_stb_o asynchronously; no ack/err delivered afterwards for that transfer.
REQ-026 After rst_ni rises, arbitration resumes on first clk_i edge.

Verification
REQ-027 Both cyc high from reset -> grant_o=01 after one edge; m0 drops cyc -> IDLE one cycle -> grant_o=10.
REQ-028 m1 owns, writes adr 0x00 CCR then reads adr 0x08, m0 requests meanwhile -> m0 stalled (ack 0) until m1_cyc_i low, then granted.
REQ-029 Slave returns s_ack_i with s_dat_i=32'hA5A5_5A5A to owner m0 -> m0_ack_o=1, m0_dat_o=A5A55A5A, m1_dat_o=0, m1_ack_o=0.
REQ-030 TIMEOUT=8, slave never acks -> s_stb_o high 8 cycles, then m1_err_o=1 and s_stb_o=0 for one cycle, ownership kept.
REQ-031 Ack arrives on same cycle as abort -> ack delivered, err stays 0.
REQ-032 rst_ni pulsed low mid-transfer while OWN1 -> s_cyc_o=0 immediately, grant_o=00, next tie goes to m0.

Source files
------------

// File: rtl/qspi_wb_arbiter_if.sv
// Bus bundle between the two Wishbone masters (instruction fetch m0, data m1),
// the arbiter, and the single SPI-controller slave port.
interface qspi_wb_arbiter_if;
    logic        m0_cyc_i, m0_stb_i, m0_we_i;
    logic [7:0]  m0_adr_i;
    logic [31:0] m0_dat_i;
    logic [3:0]  m0_sel_i;
    logic        m0_ack_o, m0_err_o;
    logic [31:0] m0_dat_o;

    logic        m1_cyc_i, m1_stb_i, m1_we_i;
    logic [7:0]  m1_adr_i;
    logic [31:0] m1_dat_i;
    logic [3:0]  m1_sel_i;
    logic        m1_ack_o, m1_err_o;
    logic [31:0] m1_dat_o;

    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [7:0]  s_adr_o;
    logic [31:0] s_dat_o;
    logic [3:0]  s_sel_o;
    logic        s_ack_i;
    logic [31:0] s_dat_i;

    // Arbiter view: consumes master requests and slave responses.
    modport slave (
        input  m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i, m0_sel_i,
        input  m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_sel_i,
        output m0_ack_o, m0_err_o, m0_dat_o, m1_ack_o, m1_err_o, m1_dat_o,
        output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
        input  s_ack_i, s_dat_i
    );

    // Environment view: drives requests and slave responses.
    modport master (
        output m0_cyc_i, m0_stb_i, m0_we_i, m0_adr_i, m0_dat_i, m0_sel_i,
        output m1_cyc_i, m1_stb_i, m1_we_i, m1_adr_i, m1_dat_i, m1_sel_i,
        input  m0_ack_o, m0_err_o, m0_dat_o, m1_ack_o, m1_err_o, m1_dat_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
        output s_ack_i, s_dat_i
    );
endinterface

// File: rtl/qspi_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the QSPI controller,
// holding ownership for a whole cyc so a flash command sequence is never split.
module qspi_wb_arbiter #(
    parameter logic [15:0] TIMEOUT = 16'd4096
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    qspi_wb_arbiter_if.slave  bus,
    output logic [1:0]        grant_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

    state_t      state_q, state_d;
    logic        last_q, last_d;      // 1 = m1 granted last
    logic [15:0] cnt_q, cnt_d;
    logic        abort_q, abort_d;

    logic        own0, own1, own_cyc, stb_req, waiting, hit;
    logic        s_cyc, s_stb, s_we;
    logic [7:0]  s_adr;
    logic [31:0] s_dat;
    logic [3:0]  s_sel;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            cnt_q   <= 16'd0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            abort_q <= abort_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        own0    = (state_q == OWN0);
        own1    = (state_q == OWN1);
        s_cyc   = 1'b0;
        stb_req = 1'b0;
        s_we    = 1'b0;
        s_adr   = 8'h00;
        s_dat   = 32'h0;
        s_sel   = 4'h0;
        if (own0) begin
            s_cyc   = bus.m0_cyc_i;
            stb_req = bus.m0_stb_i;
            s_we    = bus.m0_we_i;
            s_adr   = bus.m0_adr_i;
            s_dat   = bus.m0_dat_i;
            s_sel   = bus.m0_sel_i;
        end else if (own1) begin
            s_cyc   = bus.m1_cyc_i;
            stb_req = bus.m1_stb_i;
            s_we    = bus.m1_we_i;
            s_adr   = bus.m1_adr_i;
            s_dat   = bus.m1_dat_i;
            s_sel   = bus.m1_sel_i;
        end
        own_cyc = s_cyc;
        s_stb   = stb_req & ~abort_q;

        // Abort only while the owner keeps its cycle; a dropping master gets nothing.
        waiting = s_stb & ~bus.s_ack_i;
        hit     = waiting & (cnt_q == TIMEOUT - 16'd1);
        abort_d = hit & own_cyc;
        cnt_d   = (waiting & ~hit & own_cyc) ? cnt_q + 16'd1 : 16'd0;

        unique case (state_q)
            IDLE: begin
                if (bus.m0_cyc_i && bus.m1_cyc_i) begin
                    state_d = last_q ? OWN0 : OWN1;
                    last_d  = ~last_q;
                end else if (bus.m0_cyc_i) begin
                    state_d = OWN0;
                    last_d  = 1'b0;
                end else if (bus.m1_cyc_i) begin
                    state_d = OWN1;
                    last_d  = 1'b1;
                end
            end
            OWN0:    if (!bus.m0_cyc_i) state_d = IDLE;
            OWN1:    if (!bus.m1_cyc_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.s_cyc_o  = s_cyc;
    assign bus.s_stb_o  = s_stb;
    assign bus.s_we_o   = s_we;
    assign bus.s_adr_o  = s_adr;
    assign bus.s_dat_o  = s_dat;
    assign bus.s_sel_o  = s_sel;

    // Ack beats a simultaneous abort.
    assign bus.m0_ack_o = own0 & bus.s_ack_i;
    assign bus.m1_ack_o = own1 & bus.s_ack_i;
    assign bus.m0_err_o = own0 & abort_q & ~bus.s_ack_i;
    assign bus.m1_err_o = own1 & abort_q & ~bus.s_ack_i;
    assign bus.m0_dat_o = own0 ? bus.s_dat_i : 32'h0;
    assign bus.m1_dat_o = own1 ? bus.s_dat_i : 32'h0;

    assign grant_o = {own1, own0};
endmodule

// File: tb/tb_qspi_wb_arbiter.sv
// Randomised and directed checks of qspi_wb_arbiter against a transaction-level
// ownership/timeout model; every compared cycle is printed-on-failure only.
module tb_qspi_wb_arbiter;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] grant;

    qspi_wb_arbiter_if bus();

    qspi_wb_arbiter #(.TIMEOUT(16'(TO))) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .bus     (bus),
        .grant_o (grant)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // stimulus
    logic        cyc[2], stb[2], we[2];
    logic [7:0]  adr[2];
    logic [31:0] dat[2];
    logic [3:0]  sel[2];
    logic        sack;
    logic [31:0] sdat;

    // model: owner -1 = nobody
    int owner, last, cnt;
    bit abort;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic apply();
        bus.m0_cyc_i = cyc[0]; bus.m0_stb_i = stb[0]; bus.m0_we_i = we[0];
        bus.m0_adr_i = adr[0]; bus.m0_dat_i = dat[0]; bus.m0_sel_i = sel[0];
        bus.m1_cyc_i = cyc[1]; bus.m1_stb_i = stb[1]; bus.m1_we_i = we[1];
        bus.m1_adr_i = adr[1]; bus.m1_dat_i = dat[1]; bus.m1_sel_i = sel[1];
        bus.s_ack_i  = sack;   bus.s_dat_i  = sdat;
    endtask

    task automatic model_reset();
        owner = -1; last = 1; cnt = 0; abort = 0;
    endtask

    function automatic bit exp_stb();
        return (owner >= 0) ? (stb[owner] && !abort) : 1'b0;
    endfunction

    // One clock edge of the abstract arbiter.
    task automatic model_step();
        bit waiting, fire, keep;
        if (owner < 0) begin
            if (cyc[0] && cyc[1]) owner = (last == 1) ? 0 : 1;
            else if (cyc[0])      owner = 0;
            else if (cyc[1])      owner = 1;
            if (owner >= 0) last = owner;
            cnt = 0; abort = 0;
        end else begin
            waiting = exp_stb() && !sack;
            fire    = waiting && (cnt == TO - 1);
            keep    = cyc[owner];
            abort   = fire && keep;
            cnt     = (waiting && !fire && keep) ? cnt + 1 : 0;
            if (!keep) owner = -1;
        end
    endtask

    // Called just after a falling edge; compares all outputs, then crosses one rising edge.
    task automatic cycle(input string tag);
        logic [14:0] sb_exp;
        logic [1:0]  rsp_got[2];
        logic [31:0] dat_got[2];
        apply();
        #1;
        sb_exp = (owner >= 0) ? {cyc[owner], exp_stb(), we[owner], adr[owner], sel[owner]} : 15'h0;
        chk({tag, "_grant"}, 64'(grant), (owner == 0) ? 64'd1 : (owner == 1) ? 64'd2 : 64'd0);
        chk({tag, "_sreq"}, 64'({bus.s_cyc_o, bus.s_stb_o, bus.s_we_o, bus.s_adr_o, bus.s_sel_o}), 64'(sb_exp));
        chk({tag, "_sdat"}, 64'(bus.s_dat_o), (owner >= 0) ? 64'(dat[owner]) : 64'd0);
        rsp_got[0] = {bus.m0_ack_o, bus.m0_err_o}; dat_got[0] = bus.m0_dat_o;
        rsp_got[1] = {bus.m1_ack_o, bus.m1_err_o}; dat_got[1] = bus.m1_dat_o;
        for (int n = 0; n < 2; n++) begin
            chk($sformatf("%s_m%0d_rsp", tag, n), 64'(rsp_got[n]),
                64'({owner == n && sack, owner == n && abort && !sack}));
            chk($sformatf("%s_m%0d_dat", tag, n), 64'(dat_got[n]), (owner == n) ? 64'(sdat) : 64'd0);
        end
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    initial begin
        int  nstb;
        bit  seen;
        for (int n = 0; n < 2; n++) begin
            cyc[n] = 0; stb[n] = 0; we[n] = 0; adr[n] = 0; dat[n] = 0; sel[n] = 0;
        end
        sack = 0; sdat = 0;
        apply();
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_sreq", 64'({bus.s_cyc_o, bus.s_stb_o}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // both request from reset: m0 first, then m1 after one idle cycle
        cyc[0] = 1; stb[0] = 1; cyc[1] = 1; stb[1] = 1; sel[0] = 4'hF; sel[1] = 4'h3;
        cycle("tie");
        chk("tie_m0_first", 64'(grant), 64'd1);
        cyc[0] = 0; sack = 1;
        cycle("m0_drop");
        chk("gap_idle", 64'(grant), 64'd0);
        sack = 0;
        cycle("gap");
        chk("then_m1", 64'(grant), 64'd2);
        cyc[1] = 0;
        cycle("m1_rel");

        // m1 CCR write then DR read while m0 waits
        cyc[1] = 1; stb[1] = 1; we[1] = 1; adr[1] = 8'h00; dat[1] = 32'h0000_0123;
        cycle("m1_req");
        sack = 1;
        cycle("m1_ccr");
        cyc[0] = 1; stb[0] = 1; we[1] = 0; adr[1] = 8'h08; sdat = 32'h1234_5678;
        cycle("m1_dr");
        chk("m0_stalled", 64'(grant), 64'd2);
        cyc[1] = 0; sack = 0;
        cycle("m1_done");
        cycle("idle2");
        chk("m0_granted", 64'(grant), 64'd1);

        // slave data routed only to owner m0
        sack = 1; sdat = 32'hA5A5_5A5A;
        apply(); #1;
        chk("a5_m0", 64'({bus.m0_ack_o, bus.m0_dat_o}), {31'd0, 1'b1, 32'hA5A5_5A5A});
        chk("a5_m1", 64'({bus.m1_ack_o, bus.m1_dat_o}), 64'd0);
        cycle("a5");
        cyc[0] = 0; sack = 0;
        cycle("m0_rel");

        // timeout: m1 strobes, slave silent
        cyc[1] = 1; stb[1] = 1;
        cycle("to_req");
        nstb = 0; seen = 0;
        for (int i = 0; i < 14; i++) begin
            apply(); #1;
            if (bus.m1_err_o) begin
                seen = 1;
                chk("to_stb_low", 64'(bus.s_stb_o), 64'd0);
                chk("to_kept", 64'(grant), 64'd2);
                break;
            end
            if (bus.s_stb_o) nstb++;
            cycle("to_wait");
        end
        chk("to_err_seen", 64'(seen), 64'd1);
        chk("to_stb_cycles", 64'(nstb), 64'(TO));
        cycle("to_abort");

        // ack on the abort cycle wins
        repeat (TO) cycle("to2_wait");
        sack = 1;
        apply(); #1;
        chk("ack_vs_abort", 64'({bus.m1_ack_o, bus.m1_err_o}), 64'b10);
        cycle("ack_abort");
        sack = 0;

        // async reset while m1 owns, m0 also requesting
        cyc[0] = 1; stb[0] = 1;
        cycle("pre_rst");
        apply();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_scyc", 64'({bus.s_cyc_o, bus.s_stb_o}), 64'd0);
        chk("arst_grant", 64'(grant), 64'd0);
        chk("arst_rsp", 64'({bus.m1_ack_o, bus.m1_err_o}), 64'd0);
        model_reset();
        #1 rst_n = 1'b1;
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("post_rst_tie", 64'(grant), 64'd1);

        // randomised traffic
        for (int i = 0; i < 2000; i++) begin
            for (int n = 0; n < 2; n++) begin
                if ($urandom_range(0, 9) == 0) cyc[n] = ~cyc[n];
                stb[n] = ($urandom_range(0, 3) != 0);
                we[n]  = 1'($urandom);
                adr[n] = 8'($urandom);
                dat[n] = $urandom;
                sel[n] = 4'($urandom);
            end
            sack = ($urandom_range(0, 11) == 0);
            sdat = $urandom;
            cycle("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
